// File: rtl/oldland_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the instruction-fetch
// port and the data port, with a registered request/ack handshake and a
// bus timeout so a silent slave cannot stall the pipeline forever.
module oldland_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rd_data,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_data,
    input  logic [3:0]  d_bytesel,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rd_data,
    output logic        m_access,
    output logic [31:0] m_addr,
    output logic        m_wr_en,
    output logic [31:0] m_wr_data,
    output logic [3:0]  m_bytesel,
    input  logic        m_ack,
    input  logic [31:0] m_rd_data
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_n;
    // last_grant doubles as "current owner" while BUSY: 0 = fetch, 1 = data
    logic          last_grant, last_grant_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          i_ack_n, i_err_n, d_ack_n, d_err_n;
    logic [31:0]   i_rd_data_n, d_rd_data_n;
    logic          m_access_n, m_wr_en_n;
    logic [31:0]   m_addr_n, m_wr_data_n;
    logic [3:0]    m_bytesel_n;

    logic          pick_d;
    logic          timeout_hit;

    // On a tie the port that did not own the bus last time wins
    assign pick_d      = d_req && (!i_req || !last_grant);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // Next-state and next-output logic; acks default low so they last one cycle
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        i_ack_n      = 1'b0;
        i_err_n      = 1'b0;
        d_ack_n      = 1'b0;
        d_err_n      = 1'b0;
        i_rd_data_n  = i_rd_data;
        d_rd_data_n  = d_rd_data;
        m_access_n   = m_access;
        m_addr_n     = m_addr;
        m_wr_en_n    = m_wr_en;
        m_wr_data_n  = m_wr_data;
        m_bytesel_n  = m_bytesel;

        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_n      = BUSY;
                    last_grant_n = pick_d;
                    cnt_n        = '0;
                    m_access_n   = 1'b1;
                    if (pick_d) begin
                        m_addr_n    = d_addr;
                        m_wr_en_n   = d_wr_en;
                        m_wr_data_n = d_wr_data;
                        m_bytesel_n = d_bytesel;
                    end else begin
                        m_addr_n    = i_addr;
                        m_wr_en_n   = 1'b0;
                        m_wr_data_n = '0;
                        m_bytesel_n = 4'b1111;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt + 1'b1;
                // A slave ack in the expiry cycle still counts as success
                if (m_ack) begin
                    state_n    = RESP;
                    m_access_n = 1'b0;
                    if (last_grant) begin
                        d_ack_n     = 1'b1;
                        d_rd_data_n = m_wr_en ? 32'd0 : m_rd_data;
                    end else begin
                        i_ack_n     = 1'b1;
                        i_rd_data_n = m_rd_data;
                    end
                end else if (timeout_hit) begin
                    state_n    = RESP;
                    m_access_n = 1'b0;
                    if (last_grant) begin
                        d_ack_n     = 1'b1;
                        d_err_n     = 1'b1;
                        d_rd_data_n = '0;
                    end else begin
                        i_ack_n     = 1'b1;
                        i_err_n     = 1'b1;
                        i_rd_data_n = '0;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, arbitration history, timeout counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            cnt        <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            i_rd_data  <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rd_data  <= '0;
            m_access   <= 1'b0;
            m_addr     <= '0;
            m_wr_en    <= 1'b0;
            m_wr_data  <= '0;
            m_bytesel  <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            i_ack      <= i_ack_n;
            i_err      <= i_err_n;
            i_rd_data  <= i_rd_data_n;
            d_ack      <= d_ack_n;
            d_err      <= d_err_n;
            d_rd_data  <= d_rd_data_n;
            m_access   <= m_access_n;
            m_addr     <= m_addr_n;
            m_wr_en    <= m_wr_en_n;
            m_wr_data  <= m_wr_data_n;
            m_bytesel  <= m_bytesel_n;
        end
    end

endmodule

// File: doc/oldland_bus_arbiter.md
Name: oldland_bus_arbiter

Overview:
- Shares one external memory bus between the CPU's instruction-fetch port and its data (load/store) port.
- Sits between the fetch/memory stages and the single system bus.
- Arbitrates with round-robin priority and sequences each transfer through a registered request/ack handshake.
- A bus timeout counter prevents a hung slave from deadlocking the pipeline.

Parameters:
- TIMEOUT, 16: cycles in BUSY without m_ack before the transfer aborts with error. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  instruction fetch request, level, held until i_ack
- i_addr  in  32  fetch word address
- i_ack  out  1  one-cycle completion pulse to fetch
- i_err  out  1  valid with i_ack; 1 = timed out
- i_rd_data  out  32  fetched word, valid with i_ack
- d_req  in  1  data request, level, held until d_ack
- d_addr  in  32  data address
- d_wr_en  in  1  1 = store, 0 = load
- d_wr_data  in  32  store data
- d_bytesel  in  4  byte lane enables
- d_ack  out  1  one-cycle completion pulse to memory stage
- d_err  out  1  valid with d_ack; 1 = timed out
- d_rd_data  out  32  load data, valid with d_ack
- m_access  out  1  bus transfer active
- m_addr  out  32  bus address
- m_wr_en  out  1  bus write
- m_wr_data  out  32  bus write data
- m_bytesel  out  4  bus byte enables
- m_ack  in  1  slave completion, one cycle
- m_rd_data  in  32  slave read data, valid with m_ack

Behaviour:
- Reset (async, rst_n low): state IDLE, last_grant=I, timeout counter 0.
- Reset output values: all outputs 0, including m_access, acks, errs, rd_data, m_* fields.
- All outputs are registered.
- States: IDLE, BUSY, RESP.
- IDLE: if neither req is set, stay in IDLE.
  - If only one req is set, grant that requester.
  - If both are set, grant the one not equal to last_grant; after reset D therefore wins the first tie.
  - On grant: next cycle m_access=1, m_* fields loaded, last_grant updated, counter cleared, go to BUSY.
- Grant field mapping:
  - I grant: m_wr_en=0, m_bytesel=4'b1111, m_wr_data=0.
  - D grant: d_* fields copied to m_*.
- BUSY: m_* fields are held stable; the counter increments each cycle.
  - On m_ack: capture m_rd_data into the granted rd_data output (0 for stores); next cycle m_access=0, granted ack=1, err=0; go to RESP.
  - Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no m_ack, next cycle m_access=0, granted ack=1, err=1, rd_data=0; go to RESP.
  - m_ack in the same cycle as timeout expiry: m_ack wins, err=0.
- RESP: ack/err held for exactly this one cycle, then cleared; go to IDLE.
  - rd_data holds its value until the next ack to the same port.
  - Requests are not sampled in RESP. The requester drops req or presents a new request in the cycle after ack.
- Latency: req sampled at edge N gives m_access at N+1. m_ack at cycle M gives ack at M+1. The next grant is possible at M+2 (m_access at M+3).
- m_ack while not in BUSY: ignored.
- Request changes while not granted are allowed. Granted request fields are latched; later changes have no effect until ack.
- The non-granted requester waits; no ack is issued to it.
- rst_n asserted mid-transfer: immediate abort, all outputs 0, no ack issued. A late m_ack after reset is ignored.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x100; slave acks 2 cycles after m_access with 0xDEADBEEF -> m_access at cycle 1, m_addr=0x100, m_bytesel=4'hF, m_wr_en=0; i_ack=1, i_rd_data=0xDEADBEEF, i_err=0 at cycle 4; d_ack never pulses.
2. Store: d_req=1, d_addr=0x2000, d_wr_en=1, d_wr_data=0x12345678, d_bytesel=4'b0011 -> m_* fields match exactly; d_ack pulses one cycle after m_ack; d_rd_data=0.
3. Simultaneous requests after reset, both held -> grant order D, I, D, I over 4 transfers; m_access never overlaps; each ack is exactly one cycle wide.
4. Timeout: TIMEOUT=16, slave never acks -> m_access high for exactly 16 cycles, then i_ack=1, i_err=1, i_rd_data=0; next request proceeds normally.
5. m_ack coincident with the last timeout cycle -> ack with err=0 and slave data.
6. rst_n pulsed low in the middle of BUSY, with a stray m_ack afterwards -> all outputs 0 immediately; no ack is ever issued; the next i_req is serviced normally with D winning the first tie.
